// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data-memory responder.
//   mem_funct3_e : RISC-V load/store funct3 encodings understood by the block
//   mem_size_e   : access size derived from funct3
//   dmem_state_e : responder FSM states
package dmem_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_funct3_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational byte-lane steering for the data memory.
// Decodes funct3, flags illegal requests, builds the store byte-enable mask and
// replicated store data, and extracts/extends load data from the addressed word.
// Build option: DMEM_MISALIGN_ERR_EN makes misaligned halfword/word accesses an
// error; otherwise the offset is force-aligned to the access size.
// Ports:
//   i_write    : 1 = store, 0 = load
//   i_ctrl     : funct3
//   i_addr_lo  : byte offset within the word
//   i_wdata    : right-aligned store data
//   i_mem_word : current contents of the addressed word
//   o_be       : byte write enables (zero on error or load)
//   o_wdata    : store data replicated across lanes
//   o_load     : extended load result (zero for stores and errors)
//   o_err      : illegal funct3 (or misalignment when enabled)
module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    i_write,
    input  logic [2:0]              i_ctrl,
    input  logic [1:0]              i_addr_lo,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH-1:0]   i_mem_word,
    output logic [DATA_WIDTH/8-1:0] o_be,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH-1:0]   o_load,
    output logic                    o_err
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;

    mem_size_e             w_size;
    logic                  w_signed;
    logic                  w_legal;
    logic [1:0]            w_off;
    logic [NumBytes-1:0]   w_base_mask;
    logic [DATA_WIDTH-1:0] w_shifted;

    always_comb begin
        w_size   = SZ_B;
        w_signed = 1'b0;
        w_legal  = 1'b1;
        case (i_ctrl)
            MEM_B:   w_signed = 1'b1;
            MEM_H: begin
                w_size   = SZ_H;
                w_signed = 1'b1;
            end
            MEM_W:   w_size = SZ_W;
            // Unsigned variants only exist for loads.
            MEM_BU:  w_legal = !i_write;
            MEM_HU: begin
                w_size  = SZ_H;
                w_legal = !i_write;
            end
            default: w_legal = 1'b0;
        endcase
    end

`ifdef DMEM_MISALIGN_ERR_EN
    logic w_misalign;
    assign w_misalign = ((w_size == SZ_H) && i_addr_lo[0]) ||
                        ((w_size == SZ_W) && (i_addr_lo != 2'b00));
    assign o_err      = !w_legal || w_misalign;
`else
    assign o_err      = !w_legal;
`endif

    // Offset cleared to the access size; when misalignment is an error the
    // result is discarded anyway, so one path serves both builds.
    always_comb begin
        w_off       = i_addr_lo;
        w_base_mask = '0;
        w_base_mask[0] = 1'b1;
        o_wdata     = {NumBytes{i_wdata[7:0]}};
        case (w_size)
            SZ_H: begin
                w_off          = {i_addr_lo[1], 1'b0};
                w_base_mask[1] = 1'b1;
                o_wdata        = {(NumBytes/2){i_wdata[15:0]}};
            end
            SZ_W: begin
                w_off       = 2'b00;
                w_base_mask = '1;
                o_wdata     = i_wdata;
            end
            default: ;
        endcase
    end

    assign o_be      = (o_err || !i_write) ? '0 : (w_base_mask << w_off);
    assign w_shifted = i_mem_word >> {w_off, 3'b000};

    always_comb begin
        o_load = '0;
        if (!i_write && !o_err) begin
            case (w_size)
                SZ_B:    o_load = {{(DATA_WIDTH-8){w_shifted[7] & w_signed}}, w_shifted[7:0]};
                SZ_H:    o_load = {{(DATA_WIDTH-16){w_shifted[15] & w_signed}}, w_shifted[15:0]};
                default: o_load = i_mem_word;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding data memory with valid/ready request
// and response channels and a fixed WAIT_CYCLES access latency.
// Build option: DMEM_MISALIGN_ERR_EN (see dmem_lane_align) selects whether
// misaligned accesses are errors or force-aligned.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   req_valid/req_ready  : request handshake (ready only in IDLE)
//   req_write, req_ctrl  : store flag, funct3
//   req_addr, req_wdata  : byte address, right-aligned store data
//   rsp_valid/rsp_ready  : response handshake
//   rsp_rdata, rsp_err   : load result, error flag (held until handshake)
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned WAIT_CYCLES   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [2:0]               req_ctrl,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err
);

    localparam int unsigned Depth = 2 ** (ADDRESS_WIDTH - 2);

    dmem_state_e              r_state, w_state_next;
    logic [3:0]               r_cnt, w_cnt_next;
    logic                     r_write;
    logic [2:0]               r_ctrl;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic                     r_err;
    logic [DATA_WIDTH-1:0]    r_mem [Depth];

    logic                     w_accept;
    logic                     w_commit;
    logic                     w_sel_write;
    logic [2:0]               w_sel_ctrl;
    logic [ADDRESS_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0]    w_sel_wdata;
    logic [DATA_WIDTH-1:0]    w_mem_word;
    logic [DATA_WIDTH/8-1:0]  w_be;
    logic [DATA_WIDTH-1:0]    w_wdata_al;
    logic [DATA_WIDTH-1:0]    w_load;
    logic                     w_err;

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign w_accept  = req_valid && req_ready;

    // With zero wait cycles the commit happens on the accepting edge, so the
    // lane logic must see the live request rather than the captured copy.
    assign w_sel_write = (r_state == IDLE) ? req_write : r_write;
    assign w_sel_ctrl  = (r_state == IDLE) ? req_ctrl  : r_ctrl;
    assign w_sel_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_sel_wdata = (r_state == IDLE) ? req_wdata : r_wdata;

    // Word index uses exactly ADDRESS_WIDTH-2 bits, so addresses wrap naturally.
    assign w_mem_word  = r_mem[w_sel_addr[ADDRESS_WIDTH-1:2]];

    dmem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane_align (
        .i_write    (w_sel_write),
        .i_ctrl     (w_sel_ctrl),
        .i_addr_lo  (w_sel_addr[1:0]),
        .i_wdata    (w_sel_wdata),
        .i_mem_word (w_mem_word),
        .o_be       (w_be),
        .o_wdata    (w_wdata_al),
        .o_load     (w_load),
        .o_err      (w_err)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_next = RESP;
                        w_commit     = 1'b1;
                    end else begin
                        w_state_next = ACCESS;
                        w_cnt_next   = 4'(WAIT_CYCLES);
                    end
                end
            end
            ACCESS: begin
                if (r_cnt <= 4'd1) begin
                    w_state_next = RESP;
                    w_cnt_next   = 4'd0;
                    w_commit     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_ctrl  <= 3'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_write <= req_write;
                r_ctrl  <= req_ctrl;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_commit) begin
                r_rdata <= w_load;
                r_err   <= w_err;
            end else if ((r_state == RESP) && rsp_ready) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    // Storage is never reset; a reset asserted on the commit edge blocks the write.
    always_ff @(posedge clk) begin
        if (w_commit && !rst) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (w_be[b]) begin
                    r_mem[w_sel_addr[ADDRESS_WIDTH-1:2]][b*8 +: 8] <= w_wdata_al[b*8 +: 8];
                end
            end
        end
    end

endmodule
